capture_fsm: RTL

CAPTURE_FSM -- requirements
Module: capture_fsm

---
 rtl/capture_pkg.sv | 19 +
 rtl/edge_det.sv | 18 +
 rtl/capture_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types for the capture controller: FSM state encoding and host command codes.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_POST    = 3'd2,
    ST_DONE    = 3'd3,
    ST_READOUT = 3'd4
  } capture_state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_ARM   = 2'd1,
    CMD_READ  = 2'd2,
    CMD_ABORT = 2'd3
  } capture_cmd_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: one-cycle pulse when d goes 0 -> 1, history cleared by reset.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/capture_fsm.sv
// Acquisition capture controller: arms on host command, records pre/post-trigger
// samples into an external buffer, then streams them out on READ.
module capture_fsm
  import capture_pkg::*;
#(
  parameter int CNT_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       trigger,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic       delay_match,
  input  logic       read_match,
  input  logic       rd_ready,
  output logic       en_cnt,
  output logic       clr_cnt,
  output logic       buf_we,
  output logic       buf_re,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  if (CNT_BITS < 1) begin : g_cnt_bits_chk
    $error("capture_fsm: CNT_BITS must be at least 1");
  end

  capture_state_t state_q, state_d;
  capture_cmd_t   cmd;
  logic           trig_pend_q, trig_pend_d;
  logic           cmd_err_q, cmd_err_d;
  logic           done_first_q;
  logic           trigger_rise;
  logic           abort_req;

  edge_det u_trig_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trigger),
    .rise  (trigger_rise)
  );

  assign cmd       = capture_cmd_t'(cmd_op);
  assign abort_req = cmd_valid && (cmd == CMD_ABORT);
  assign cmd_err   = cmd_err_q;

  // NOTE: every output and next-state signal gets a default first, so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    trig_pend_d = trig_pend_q;
    cmd_err_d   = 1'b0;
    en_cnt      = 1'b0;
    clr_cnt     = 1'b0;
    buf_we      = 1'b0;
    buf_re      = 1'b0;
    rd_valid    = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        clr_cnt     = 1'b1;
        trig_pend_d = 1'b0;
      end
      ST_ARMED: begin
        buf_we = sample_tick;
        if (trigger_rise) trig_pend_d = 1'b1;
        // The tick that coincides with (or follows) the trigger is stored but not counted.
        if (sample_tick && (trig_pend_q || trigger_rise)) begin
          state_d     = ST_POST;
          trig_pend_d = 1'b0;
        end
      end
      ST_POST: begin
        if (delay_match) begin
          state_d = ST_DONE;
        end else begin
          buf_we = sample_tick;
          en_cnt = sample_tick;
        end
      end
      ST_DONE: begin
        clr_cnt = done_first_q;
      end
      ST_READOUT: begin
        rd_valid = ~read_match;
        if (read_match) begin
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          buf_re = 1'b1;
          en_cnt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_valid) begin
      unique case (cmd)
        CMD_ARM: begin
          if (state_q == ST_IDLE) state_d   = ST_ARMED;
          else                    cmd_err_d = 1'b1;
        end
        CMD_READ: begin
          if (state_q == ST_DONE) state_d   = ST_READOUT;
          else                    cmd_err_d = 1'b1;
        end
        CMD_ABORT: begin
          // Abort wins over any concurrent tick or handshake in this cycle.
          state_d     = ST_IDLE;
          trig_pend_d = 1'b0;
          en_cnt      = 1'b0;
          buf_we      = 1'b0;
          buf_re      = 1'b0;
          rd_valid    = 1'b0;
        end
        default: ;
      endcase
    end

    // A reset cycle presents idle outputs so no buffer access escapes mid-abort.
    if (!rst_n) begin
      en_cnt   = 1'b0;
      clr_cnt  = 1'b1;
      buf_we   = 1'b0;
      buf_re   = 1'b0;
      rd_valid = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      trig_pend_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      done_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_pend_q  <= trig_pend_d;
      cmd_err_q    <= cmd_err_d;
      done_first_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

endmodule
